// File: rtl/multicycle_mips_control_if.sv
// rtl/multicycle_mips_control_if.sv - controller-to-datapath/memory control bus
interface multicycle_mips_control_if #(
    parameter int STATE_W = 4
);
    // status coming back from the datapath and memory
    logic [5:0]         opcode;
    logic               zero;
    logic               rs_neg;
    logic               n_flag;
    logic               mem_ready;

    // control driven by the controller
    logic               pc_write;
    logic [1:0]         iord;
    logic               mem_read;
    logic               mem_write;
    logic               mem_data_src;
    logic               ir_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               zext;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero, rs_neg, n_flag, mem_ready,
        output pc_write, iord, mem_read, mem_write, mem_data_src, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zext,
               alu_op, pc_source, illegal, state
    );

    modport slave (
        output opcode, zero, rs_neg, n_flag, mem_ready,
        input  pc_write, iord, mem_read, mem_write, mem_data_src, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zext,
               alu_op, pc_source, illegal, state
    );
endinterface

// File: rtl/multicycle_mips_control.sv
// rtl/multicycle_mips_control.sv - multicycle MIPS-lite control state machine
module multicycle_mips_control #(
    parameter int STATE_W = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_mips_control_if.master     bus
);
    localparam logic [5:0] OP_R      = 6'd0;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_ORI    = 6'd13;
    localparam logic [5:0] OP_BLTZAL = 6'd34;
    localparam logic [5:0] OP_JSPAL  = 6'd19;
    localparam logic [5:0] OP_BALN   = 6'd27;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEXEC  = 4'd6,
        RTWB    = 4'd7,
        BEQ     = 4'd8,
        JUMP    = 4'd9,
        ORIEXEC = 4'd10,
        ORIWB   = 4'd11,
        BLTZAL  = 4'd12,
        BALN    = 4'd13,
        JSPAL   = 4'd14,
        UNUSED  = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;

    assign bus.state = STATE_W'(state_q);

    // state register; reset lands in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and control decode; reset forces every control output low
    always_comb begin
        state_d          = FETCH;
        bus.pc_write     = 1'b0;
        bus.iord         = 2'b00;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_data_src = 1'b0;
        bus.ir_write     = 1'b0;
        bus.reg_dst      = 2'b00;
        bus.mem_to_reg   = 2'b00;
        bus.reg_write    = 1'b0;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'b00;
        bus.zext         = 1'b0;
        bus.alu_op       = 2'b00;
        bus.pc_source    = 2'b00;
        bus.illegal      = 1'b0;

        if (!reset) begin
            unique case (state_q)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = DECODE;
                    end else begin
                        state_d      = FETCH;
                    end
                end
                DECODE: begin
                    // ALUOut picks up the branch target while the opcode is decoded
                    bus.alu_src_b = 2'b11;
                    case (bus.opcode)
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_R:         state_d = RTEXEC;
                        OP_ORI:       state_d = ORIEXEC;
                        OP_BEQ:       state_d = BEQ;
                        OP_J:         state_d = JUMP;
                        OP_BLTZAL:    state_d = BLTZAL;
                        OP_BALN:      state_d = BALN;
                        OP_JSPAL:     state_d = JSPAL;
                        default: begin
                            bus.illegal = 1'b1;
                            state_d     = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    // IR is stable, so the opcode still tells load from store
                    state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 2'b01;
                    state_d      = bus.mem_ready ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 2'b01;
                end
                MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 2'b01;
                    state_d       = bus.mem_ready ? FETCH : MEMWR;
                end
                RTEXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                    state_d       = RTWB;
                end
                RTWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'b01;
                end
                BEQ: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b01;
                    bus.pc_source = 2'b01;
                    bus.pc_write  = bus.zero;
                end
                JUMP: begin
                    bus.pc_source = 2'b10;
                    bus.pc_write  = 1'b1;
                end
                ORIEXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.zext      = 1'b1;
                    bus.alu_op    = 2'b11;
                    state_d       = ORIWB;
                end
                ORIWB: begin
                    bus.reg_write = 1'b1;
                end
                BLTZAL: begin
                    // link and branch share the cycle; PC already holds PC+4
                    bus.pc_source  = 2'b01;
                    bus.reg_dst    = 2'b10;
                    bus.mem_to_reg = 2'b10;
                    bus.pc_write   = bus.rs_neg;
                    bus.reg_write  = bus.rs_neg;
                end
                BALN: begin
                    bus.pc_source  = 2'b10;
                    bus.reg_dst    = 2'b10;
                    bus.mem_to_reg = 2'b10;
                    bus.pc_write   = bus.n_flag;
                    bus.reg_write  = bus.n_flag;
                end
                JSPAL: begin
                    // return address goes out first; PC only moves once the store lands
                    bus.mem_write    = 1'b1;
                    bus.iord         = 2'b10;
                    bus.mem_data_src = 1'b1;
                    bus.pc_source    = 2'b10;
                    bus.pc_write     = bus.mem_ready;
                    state_d          = bus.mem_ready ? FETCH : JSPAL;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_mips_control.sv
// tb/tb_multicycle_mips_control.sv - directed self-checking bench for the controller
module tb_multicycle_mips_control;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    multicycle_mips_control_if #(.STATE_W(4)) bus ();

    multicycle_mips_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] all_ctrl();
        return {11'd0, bus.pc_write, bus.iord, bus.mem_read, bus.mem_write,
                bus.mem_data_src, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.zext,
                bus.alu_op, bus.pc_source, bus.illegal};
    endfunction

    // from FETCH with a ready memory into DECODE, then present the opcode
    task automatic fetch_decode(input logic [5:0] op, input string tag);
        check({tag, "_fetch_state"}, 32'(bus.state), 32'd0);
        bus.mem_ready = 1'b1;
        settle();
        check({tag, "_fetch_irw"}, 32'(bus.ir_write), 32'd1);
        tick();
        check({tag, "_decode_state"}, 32'(bus.state), 32'd1);
        bus.opcode = op;
        settle();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;
        bus.rs_neg    = 1'b0;
        bus.n_flag    = 1'b0;
        bus.mem_ready = 1'b1;

        // reset held two cycles
        tick();
        check("rst1_state", 32'(bus.state), 32'd0);
        check("rst1_outs", all_ctrl(), 32'd0);
        tick();
        check("rst2_state", 32'(bus.state), 32'd0);
        check("rst2_outs", all_ctrl(), 32'd0);
        reset = 1'b0;
        settle();
        check("rel_mem_read", 32'(bus.mem_read), 32'd1);
        check("rel_ir_write", 32'(bus.ir_write), 32'd1);
        check("rel_pc_write", 32'(bus.pc_write), 32'd1);
        check("rel_alu_src_b", 32'(bus.alu_src_b), 32'd1);
        tick();
        check("rel_next", 32'(bus.state), 32'd1);
        bus.opcode = 6'd0;
        tick();
        check("rt0_state", 32'(bus.state), 32'd6);
        tick();
        check("rt0_wb", 32'(bus.state), 32'd7);
        tick();

        // FETCH stalls without memory
        bus.mem_ready = 1'b0;
        settle();
        check("fstall_irw", 32'(bus.ir_write), 32'd0);
        check("fstall_pcw", 32'(bus.pc_write), 32'd0);
        tick();
        check("fstall_state", 32'(bus.state), 32'd0);

        // lw with two wait states
        fetch_decode(6'd35, "lw");
        check("lw_dec_alub", 32'(bus.alu_src_b), 32'd3);
        tick();
        check("lw_memadr", 32'(bus.state), 32'd2);
        check("lw_memadr_alub", 32'(bus.alu_src_b), 32'd2);
        bus.mem_ready = 1'b0;
        tick();
        check("lw_memrd0", 32'(bus.state), 32'd3);
        check("lw_memrd_iord", 32'(bus.iord), 32'd1);
        check("lw_memrd_rd", 32'(bus.mem_read), 32'd1);
        tick();
        check("lw_memrd1", 32'(bus.state), 32'd3);
        tick();
        check("lw_memrd2", 32'(bus.state), 32'd3);
        bus.mem_ready = 1'b1;
        tick();
        check("lw_memwb", 32'(bus.state), 32'd4);
        check("lw_wb_rw", 32'(bus.reg_write), 32'd1);
        check("lw_wb_m2r", 32'(bus.mem_to_reg), 32'd1);
        check("lw_wb_dst", 32'(bus.reg_dst), 32'd0);
        tick();

        // sw, zero wait
        fetch_decode(6'd43, "sw");
        tick();
        check("sw_memadr", 32'(bus.state), 32'd2);
        tick();
        check("sw_memwr", 32'(bus.state), 32'd5);
        check("sw_mw", 32'(bus.mem_write), 32'd1);
        check("sw_rw", 32'(bus.reg_write), 32'd0);
        tick();

        // beq not taken then taken
        fetch_decode(6'd4, "beq0");
        tick();
        check("beq0_state", 32'(bus.state), 32'd8);
        bus.zero = 1'b0;
        settle();
        check("beq0_pcw", 32'(bus.pc_write), 32'd0);
        check("beq0_aluop", 32'(bus.alu_op), 32'd1);
        tick();
        fetch_decode(6'd4, "beq1");
        bus.zero = 1'b1;
        tick();
        check("beq1_state", 32'(bus.state), 32'd8);
        check("beq1_pcw", 32'(bus.pc_write), 32'd1);
        check("beq1_pcsrc", 32'(bus.pc_source), 32'd1);
        bus.zero = 1'b0;
        tick();

        // bltzal taken then not taken
        fetch_decode(6'd34, "bl1");
        bus.rs_neg = 1'b1;
        tick();
        check("bl1_state", 32'(bus.state), 32'd12);
        check("bl1_pcw", 32'(bus.pc_write), 32'd1);
        check("bl1_rw", 32'(bus.reg_write), 32'd1);
        check("bl1_dst", 32'(bus.reg_dst), 32'd2);
        check("bl1_m2r", 32'(bus.mem_to_reg), 32'd2);
        tick();
        fetch_decode(6'd34, "bl0");
        bus.rs_neg = 1'b0;
        tick();
        check("bl0_state", 32'(bus.state), 32'd12);
        check("bl0_pcw", 32'(bus.pc_write), 32'd0);
        check("bl0_rw", 32'(bus.reg_write), 32'd0);
        tick();
        check("bl0_back", 32'(bus.state), 32'd0);

        // baln taken
        fetch_decode(6'd27, "baln");
        bus.n_flag = 1'b1;
        tick();
        check("baln_state", 32'(bus.state), 32'd13);
        check("baln_pcw", 32'(bus.pc_write), 32'd1);
        check("baln_pcsrc", 32'(bus.pc_source), 32'd2);
        bus.n_flag = 1'b0;
        tick();

        // jspal with one wait state
        fetch_decode(6'd19, "jspal");
        bus.mem_ready = 1'b0;
        tick();
        check("jsp_state0", 32'(bus.state), 32'd14);
        check("jsp_mw0", 32'(bus.mem_write), 32'd1);
        check("jsp_iord0", 32'(bus.iord), 32'd2);
        check("jsp_mds0", 32'(bus.mem_data_src), 32'd1);
        check("jsp_pcw0", 32'(bus.pc_write), 32'd0);
        tick();
        check("jsp_state1", 32'(bus.state), 32'd14);
        bus.mem_ready = 1'b1;
        settle();
        check("jsp_pcw1", 32'(bus.pc_write), 32'd1);
        check("jsp_mw1", 32'(bus.mem_write), 32'd1);
        tick();
        check("jsp_back", 32'(bus.state), 32'd0);

        // ori
        fetch_decode(6'd13, "ori");
        tick();
        check("ori_state", 32'(bus.state), 32'd10);
        check("ori_zext", 32'(bus.zext), 32'd1);
        check("ori_aluop", 32'(bus.alu_op), 32'd3);
        tick();
        check("ori_wb", 32'(bus.state), 32'd11);
        check("ori_rw", 32'(bus.reg_write), 32'd1);
        tick();

        // j
        fetch_decode(6'd2, "j");
        tick();
        check("j_state", 32'(bus.state), 32'd9);
        check("j_pcw", 32'(bus.pc_write), 32'd1);
        check("j_pcsrc", 32'(bus.pc_source), 32'd2);
        tick();

        // illegal opcode
        fetch_decode(6'd63, "ill");
        check("ill_pulse", 32'(bus.illegal), 32'd1);
        check("ill_rw", 32'(bus.reg_write), 32'd0);
        check("ill_mw", 32'(bus.mem_write), 32'd0);
        tick();
        check("ill_state", 32'(bus.state), 32'd0);
        check("ill_drop", 32'(bus.illegal), 32'd0);

        // reset while in RTEXEC aborts the instruction
        fetch_decode(6'd0, "rtab");
        tick();
        check("rtab_state", 32'(bus.state), 32'd6);
        reset = 1'b1;
        settle();
        check("rtab_outs", all_ctrl(), 32'd0);
        tick();
        check("rtab_after", 32'(bus.state), 32'd0);
        check("rtab_rw", 32'(bus.reg_write), 32'd0);
        reset = 1'b0;
        settle();
        check("rtab_fetch", 32'(bus.mem_read), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
